relogio_onehot_monitor: RTL

Receive-side checker for the one-hot clock display buses: samples the six 10-bit one-hot digit codes (hours tens/units, minutes tens/units, seconds tens/units), decodes them back to BCD, and validates code integrity, digit range and second-to-second continuity. It sits downstream of the clock core, on the display or checker side of the same digit interface. It reports per-sample error pulses, a saturating error count and a lock indication.

---
 rtl/relogio_onehot_monitor.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/relogio_onehot_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : relogio_onehot_monitor
//  Purpose  : Receive-side checker for the six one-hot clock digit buses.
//             Decodes each 10-bit one-hot code to BCD, flags malformed codes,
//             out-of-range times and breaks in second-to-second continuity,
//             keeps a saturating error count and a lock indication.
//  Ports    : clk, reset (async, active-low)
//             en        - sample strobe, one sample per cycle with en=1
//             LD        - load marker, re-seeds the reference
//             clr_err   - synchronous clear of err_count (wins over increment)
//             H/M/S_in1_oh, H/M/S_in0_oh - one-hot digit codes
//             H_bcd1..S_bcd0 - last good decoded time
//             out_valid, code_err, range_err, seq_err - one-cycle result pulses
//             err_count - saturating count of erroneous samples
//             locked    - continuity tracking established
//  Revision : 1.0 - initial release
// ============================================================================
module relogio_onehot_monitor #(
   parameter int ERR_W  = 8,
   parameter int LOCK_N = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             LD,
   input  logic             clr_err,
   input  logic [9:0]       H_in1_oh,
   input  logic [9:0]       H_in0_oh,
   input  logic [9:0]       M_in1_oh,
   input  logic [9:0]       M_in0_oh,
   input  logic [9:0]       S_in1_oh,
   input  logic [9:0]       S_in0_oh,
   output logic [1:0]       H_bcd1,
   output logic [3:0]       H_bcd0,
   output logic [3:0]       M_bcd1,
   output logic [3:0]       M_bcd0,
   output logic [3:0]       S_bcd1,
   output logic [3:0]       S_bcd0,
   output logic             out_valid,
   output logic             code_err,
   output logic             range_err,
   output logic             seq_err,
   output logic [ERR_W-1:0] err_count,
   output logic             locked
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_TRACK  = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   // Digit slot order: [5]=H tens, [4]=H units, [3]=M tens, [2]=M units,
   // [1]=S tens, [0]=S units.
   logic [5:0][9:0] w_bus;
   logic [5:0][3:0] w_dig;
   logic [5:0]      w_oh_ok;
   logic [5:0][3:0] w_succ;
   logic            w_code_err;
   logic            w_range_err;
   logic            w_good;

   state_t          state_q, state_d;
   logic [3:0]      run_q, run_d;
   logic [5:0][3:0] ref_q, ref_d;
   logic [1:0]      bcd_h1_q, bcd_h1_d;
   logic [4:0][3:0] bcd_lo_q, bcd_lo_d;
   logic            valid_q, valid_d;
   logic            code_q, code_d;
   logic            range_q, range_d;
   logic            seq_q, seq_d;
   logic [ERR_W-1:0] cnt_q, cnt_d;
   logic            locked_q, locked_d;

   function automatic logic is_onehot(input logic [9:0] v);
      return (v != 10'd0) && ((v & (v - 10'd1)) == 10'd0);
   endfunction

   // Only meaningful when the code is one-hot; otherwise the result is unused.
   function automatic logic [3:0] oh_index(input logic [9:0] v);
      logic [3:0] idx;
      idx = 4'd0;
      for (int k = 0; k < 10; k++) begin
         if (v[k]) idx = 4'(k);
      end
      return idx;
   endfunction

   assign w_bus = {H_in1_oh, H_in0_oh, M_in1_oh, M_in0_oh, S_in1_oh, S_in0_oh};

   for (genvar g = 0; g < 6; g++) begin : g_dec
      assign w_oh_ok[g] = is_onehot(w_bus[g]);
      assign w_dig[g]   = oh_index(w_bus[g]);
   end

   assign w_code_err  = ~(&w_oh_ok);
   // A malformed code makes the decoded digits meaningless, so it masks range.
   assign w_range_err = ~w_code_err &
                        ((w_dig[5] > 4'd2) ||
                         ((w_dig[5] == 4'd2) && (w_dig[4] > 4'd3)) ||
                         (w_dig[3] > 4'd5) ||
                         (w_dig[1] > 4'd5));
   assign w_good      = ~w_code_err & ~w_range_err;

   // Successor of the stored reference: ripple carry through the BCD digits.
   always_comb begin
      w_succ = ref_q;
      if (ref_q[0] != 4'd9) begin
         w_succ[0] = ref_q[0] + 4'd1;
      end else begin
         w_succ[0] = 4'd0;
         if (ref_q[1] != 4'd5) begin
            w_succ[1] = ref_q[1] + 4'd1;
         end else begin
            w_succ[1] = 4'd0;
            if (ref_q[2] != 4'd9) begin
               w_succ[2] = ref_q[2] + 4'd1;
            end else begin
               w_succ[2] = 4'd0;
               if (ref_q[3] != 4'd5) begin
                  w_succ[3] = ref_q[3] + 4'd1;
               end else begin
                  w_succ[3] = 4'd0;
                  if ((ref_q[5] == 4'd2) && (ref_q[4] == 4'd3)) begin
                     w_succ[5] = 4'd0;
                     w_succ[4] = 4'd0;
                  end else if (ref_q[4] == 4'd9) begin
                     w_succ[4] = 4'd0;
                     w_succ[5] = ref_q[5] + 4'd1;
                  end else begin
                     w_succ[4] = ref_q[4] + 4'd1;
                  end
               end
            end
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      run_d    = run_q;
      ref_d    = ref_q;
      bcd_h1_d = bcd_h1_q;
      bcd_lo_d = bcd_lo_q;
      valid_d  = en;
      code_d   = 1'b0;
      range_d  = 1'b0;
      seq_d    = 1'b0;
      cnt_d    = cnt_q;

      if (en) begin
         code_d  = w_code_err;
         range_d = w_range_err;
         if (!w_good) begin
            state_d = ST_IDLE;
            run_d   = 4'd0;
         end else begin
            bcd_h1_d = w_dig[5][1:0];
            bcd_lo_d = w_dig[4:0];
            ref_d    = w_dig;
            if (LD || (state_q == ST_IDLE)) begin
               state_d = ST_TRACK;
               run_d   = 4'd0;
            end else if (w_dig == w_succ) begin
               // Once locked the run counter stops; it only matters on the way up.
               if (state_q == ST_TRACK) begin
                  run_d = run_q + 4'd1;
                  if ((run_q + 4'd1) == 4'(LOCK_N)) state_d = ST_LOCKED;
               end
            end else begin
               seq_d   = 1'b1;
               state_d = ST_TRACK;
               run_d   = 4'd0;
            end
         end
      end

      if (clr_err) begin
         cnt_d = '0;
      end else if ((code_d | range_d | seq_d) && (cnt_q != {ERR_W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end

      locked_d = (state_d == ST_LOCKED);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         run_q    <= 4'd0;
         ref_q    <= '0;
         bcd_h1_q <= 2'd0;
         bcd_lo_q <= '0;
         valid_q  <= 1'b0;
         code_q   <= 1'b0;
         range_q  <= 1'b0;
         seq_q    <= 1'b0;
         cnt_q    <= '0;
         locked_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         run_q    <= run_d;
         ref_q    <= ref_d;
         bcd_h1_q <= bcd_h1_d;
         bcd_lo_q <= bcd_lo_d;
         valid_q  <= valid_d;
         code_q   <= code_d;
         range_q  <= range_d;
         seq_q    <= seq_d;
         cnt_q    <= cnt_d;
         locked_q <= locked_d;
      end
   end

   assign H_bcd1    = bcd_h1_q;
   assign H_bcd0    = bcd_lo_q[4];
   assign M_bcd1    = bcd_lo_q[3];
   assign M_bcd0    = bcd_lo_q[2];
   assign S_bcd1    = bcd_lo_q[1];
   assign S_bcd0    = bcd_lo_q[0];
   assign out_valid = valid_q;
   assign code_err  = code_q;
   assign range_err = range_q;
   assign seq_err   = seq_q;
   assign err_count = cnt_q;
   assign locked    = locked_q;

endmodule
`default_nettype wire
